// File: rtl/stripe_pkg.sv
// rtl/stripe_pkg.sv - shared types and constants for the stripe scheduler
package stripe_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] PAD_WORD = 32'hF7F7_F7F7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        PAD    = 2'd3
    } state_t;

endpackage

// File: rtl/stripe_scheduler_rr_arb2.sv
// rtl/stripe_scheduler_rr_arb2.sv - two-input round-robin pointer and tie-break decision
module rr_arb2 (
    input  logic       clock2,
    input  logic       reset_L,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       pick
);

    // rr_ptr names the requester that wins a tie; it moves away from whoever just finished.
    logic rr_ptr;

    always_ff @(posedge clock2 or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr <= 1'b0;
        end else if (update) begin
            rr_ptr <= ~served;
        end
    end

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = rr_ptr;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/stripe_scheduler.sv
// rtl/stripe_scheduler.sv - two-requester packet arbiter feeding a 1/2-lane striper (option: STRIPE_PAD_EN)
module stripe_scheduler
    import stripe_pkg::*;
#(
    parameter int MAX_PKT_WORDS = 64
) (
    input  logic              clock2,
    input  logic              reset_L,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_eop,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_eop,
    output logic              req1_ready,
    input  logic              lanes_2,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_sel,
    output logic [1:0]        grant,
    output logic              pkt_err
);

    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

    state_t            state;
    logic              lanes2_q;
    logic              lane_ptr;
    logic [CNT_W-1:0]  word_cnt;

    logic              accept;
    logic [DATA_W-1:0] acc_data;
    logic              acc_eop;
    logic              at_limit;
    logic              forced;
    logic              pkt_end;
    logic              next_lane;
    logic              pick;

    assign req0_ready = (state == GRANT0);
    assign req1_ready = (state == GRANT1);
    assign grant      = {state == GRANT1, state == GRANT0};

    always_comb begin
        acc_data = '0;
        acc_eop  = 1'b0;
        accept   = 1'b0;
        if (state == GRANT0) begin
            acc_data = req0_data;
            acc_eop  = req0_eop;
            accept   = req0_valid;
        end else if (state == GRANT1) begin
            acc_data = req1_data;
            acc_eop  = req1_eop;
            accept   = req1_valid;
        end
    end

    // The word that reaches the limit closes the packet just as an eop would.
    assign at_limit  = (word_cnt == CNT_W'(MAX_PKT_WORDS - 1));
    assign forced    = accept & ~acc_eop & at_limit;
    assign pkt_end   = accept & (acc_eop | at_limit);
    assign next_lane = lanes2_q ? ~lane_ptr : 1'b0;

    rr_arb2 u_rr_arb2 (
        .clock2  (clock2),
        .reset_L (reset_L),
        .req     ({req1_valid, req0_valid}),
        .update  (pkt_end),
        .served  (state == GRANT1),
        .pick    (pick)
    );

    always_ff @(posedge clock2 or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            lanes2_q  <= 1'b0;
            lane_ptr  <= 1'b0;
            word_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_sel  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            pkt_err   <= forced;

            if (accept) begin
                data_out  <= acc_data;
                valid_out <= 1'b1;
                lane_sel  <= lane_ptr;
                lane_ptr  <= next_lane;
                if (word_cnt != CNT_W'(MAX_PKT_WORDS)) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state    <= pick ? GRANT1 : GRANT0;
                        lanes2_q <= lanes_2;
                        word_cnt <= '0;
`ifdef STRIPE_PAD_EN
                        lane_ptr <= 1'b0;
`endif
                    end
                end
                GRANT0, GRANT1: begin
                    if (pkt_end) begin
                        word_cnt <= '0;
`ifdef STRIPE_PAD_EN
                        // Odd word count in two-lane mode leaves lane 1 empty; fill it.
                        state <= (lanes2_q && next_lane) ? PAD : IDLE;
`else
                        state <= IDLE;
`endif
                    end
                end
                PAD: begin
`ifdef STRIPE_PAD_EN
                    data_out  <= PAD_WORD;
                    valid_out <= 1'b1;
                    lane_sel  <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stripe_scheduler.sv
// tb/tb_stripe_scheduler.sv - directed self-checking bench for stripe_scheduler
module tb_stripe_scheduler;

    logic        clock2;
    logic        reset_L;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_eop;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_eop;
    logic        req1_ready;
    logic        lanes_2;
    logic [31:0] data_out;
    logic        valid_out;
    logic        lane_sel;
    logic [1:0]  grant;
    logic        pkt_err;

    localparam logic [31:0] PADW = 32'hF7F7_F7F7;

    int n_checks = 0;
    int n_fail   = 0;

    stripe_scheduler #(.MAX_PKT_WORDS(64)) dut (
        .clock2     (clock2),
        .reset_L    (reset_L),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_eop   (req0_eop),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_eop   (req1_eop),
        .req1_ready (req1_ready),
        .lanes_2    (lanes_2),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lane_sel   (lane_sel),
        .grant      (grant),
        .pkt_err    (pkt_err)
    );

    initial clock2 = 1'b0;
    always #5 clock2 = ~clock2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;
        logic        v0;
        logic [31:0] d0;
        logic        e0;
        logic        v1;
        logic [31:0] d1;
        logic        e1;
        logic        l2;
        logic [1:0]  gnt;
        logic [1:0]  rdy;
        logic        vo;
        logic [31:0] dout;
        logic        ls;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic v0, logic [31:0] d0, logic e0,
                                logic v1, logic [31:0] d1, logic e1, logic l2,
                                logic [1:0] gnt, logic [1:0] rdy, logic vo,
                                logic [31:0] dout, logic ls);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.e0 = e0;
        v.v1 = v1; v.d1 = d1; v.e1 = e1; v.l2 = l2;
        v.gnt = gnt; v.rdy = rdy; v.vo = vo; v.dout = dout; v.ls = ls;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = '0; req0_eop = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_eop = 1'b0;
    endtask

    // Entered and left at a falling edge; reset is released at that falling edge.
    task automatic do_reset();
        reset_L = 1'b0;
        idle_inputs();
        #1;
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_grant", {30'b0, grant}, 32'h0);
        chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        chk("rst_lane_err", {30'b0, lane_sel, pkt_err}, 32'h0);
        @(negedge clock2);
        reset_L = 1'b1;
    endtask

    int perr_cnt;
    int words;
    logic [31:0] d;
    logic acc;

    initial begin
        reset_L = 1'b0;
        lanes_2 = 1'b0;
        idle_inputs();
        @(negedge clock2);

        // req0 alone, 3 words, two lanes
        tbl.push_back(mk(1, 1, 32'hA000_0000, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hA000_0000, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hA000_0001, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 32'hA000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hA000_0002, 1, 0, 0, 0, 1, 2'b01, 2'b01, 1, 32'hA000_0001, 1));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 32'hA000_0002, 0));
`ifdef STRIPE_PAD_EN
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, PADW, 1));
`else
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 32'hA000_0002, 0));
`endif
        // both requesters from reset, 2-word packets
        tbl.push_back(mk(1, 1, 32'hB000_0000, 0, 1, 32'hC000_0000, 0, 1, 2'b00, 2'b00, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hB000_0000, 0, 1, 32'hC000_0000, 0, 1, 2'b01, 2'b01, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hB000_0001, 1, 1, 32'hC000_0000, 0, 1, 2'b01, 2'b01, 1, 32'hB000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 0, 1, 32'hC000_0000, 0, 1, 2'b00, 2'b00, 1, 32'hB000_0001, 1));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 0, 1, 32'hC000_0000, 0, 1, 2'b10, 2'b10, 0, 32'hB000_0001, 1));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 0, 1, 32'hC000_0001, 1, 1, 2'b10, 2'b10, 1, 32'hC000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 0, 1, 32'hC000_0002, 0, 1, 2'b00, 2'b00, 1, 32'hC000_0001, 1));
        tbl.push_back(mk(0, 1, 32'hB000_0002, 0, 1, 32'hC000_0002, 0, 1, 2'b01, 2'b01, 0, 32'hC000_0001, 1));
        tbl.push_back(mk(0, 1, 32'hB000_0003, 1, 1, 32'hC000_0002, 0, 1, 2'b01, 2'b01, 1, 32'hB000_0002, 0));
        // single lane, 4 words
        tbl.push_back(mk(1, 1, 32'hD000_0000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0000, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0001, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 32'hD000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0002, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 32'hD000_0001, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0003, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1, 32'hD000_0002, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'hD000_0003, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'hD000_0003, 0));
        // valid gap inside a packet
        tbl.push_back(mk(1, 1, 32'hE000_0000, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'hE000_0000, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'hE000_0001, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 32'hE000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hE000_0001, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 32'hE000_0000, 0));
        tbl.push_back(mk(0, 1, 32'hE000_0002, 1, 0, 0, 0, 1, 2'b01, 2'b01, 1, 32'hE000_0001, 1));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 32'hE000_0002, 0));
`ifdef STRIPE_PAD_EN
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, PADW, 1));
`else
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 32'hE000_0002, 0));
`endif

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_eop = tbl[i].e0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_eop = tbl[i].e1;
            lanes_2    = tbl[i].l2;
            #1;
            chk($sformatf("v%0d_grant", i), {30'b0, grant}, {30'b0, tbl[i].gnt});
            chk($sformatf("v%0d_ready", i), {30'b0, req1_ready, req0_ready}, {30'b0, tbl[i].rdy});
            chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, {31'b0, tbl[i].vo});
            chk($sformatf("v%0d_data", i), data_out, tbl[i].dout);
            chk($sformatf("v%0d_lane", i), {31'b0, lane_sel}, {31'b0, tbl[i].ls});
            chk($sformatf("v%0d_err", i), {31'b0, pkt_err}, 32'h0);
            @(negedge clock2);
        end

        // 64 words without eop: forced abort
        do_reset();
        lanes_2 = 1'b1;
        req0_valid = 1'b1;
        d = 32'h0;
        perr_cnt = 0;
        words = 0;
        for (int c = 0; c <= 66; c++) begin
            req0_data = d;
            #1;
            if (valid_out) begin
                chk("abort_data", data_out, 32'(words));
                words++;
            end
            if (pkt_err) perr_cnt++;
            if (c == 64) chk("abort_grant_last", {30'b0, grant}, 32'h1);
            if (c == 65) begin
                chk("abort_grant_released", {30'b0, grant}, 32'h0);
                chk("abort_err_pulse", {31'b0, pkt_err}, 32'h1);
            end
            if (c == 66) chk("abort_regrant", {30'b0, grant}, 32'h1);
            acc = req0_ready;
            @(negedge clock2);
            if (acc) d = d + 32'h1;
        end
        chk("abort_err_count", 32'(perr_cnt), 32'h1);
        chk("abort_word_count", 32'(words), 32'd64);

        // reset on 2nd word of a 5-word packet
        do_reset();
        lanes_2 = 1'b1;
        req0_valid = 1'b1; req0_data = 32'hF000_0000;
        @(negedge clock2);
        @(negedge clock2);
        req0_data = 32'hF000_0001;
        #1;
        chk("midrst_pre_valid", {31'b0, valid_out}, 32'h1);
        reset_L = 1'b0;
        #1;
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_flags", {26'b0, valid_out, lane_sel, grant, pkt_err, req0_ready}, 32'h0);
        chk("midrst_ready1", {31'b0, req1_ready}, 32'h0);
        @(negedge clock2);
        reset_L = 1'b1;
        req0_data = 32'h6000_0000; req0_eop = 1'b0;
        @(negedge clock2);
        @(negedge clock2);
        req0_data = 32'h6000_0001; req0_eop = 1'b1;
        #1;
        chk("midrst_new_data", data_out, 32'h6000_0000);
        chk("midrst_new_lane", {31'b0, valid_out, lane_sel}, 32'h2);
        @(negedge clock2);
        req0_valid = 1'b0; req0_eop = 1'b0;
        #1;
        chk("midrst_new_data1", data_out, 32'h6000_0001);
        chk("midrst_new_lane1", {31'b0, valid_out, lane_sel}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
